// File: rtl/di_scan_pkg.sv
// Shared types and default sizing for the scanned digital-input debounce block.
package di_scan_pkg;

  localparam int N_CH_DEF       = 8;
  localparam int CNT_W_DEF      = 6;
  localparam int SHAKE_DEF      = 50;
  localparam int FIFO_DEPTH_DEF = 8;

  localparam int CH_W = $clog2(N_CH_DEF);

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            level;
  } evt_t;

  // Outcome of serving one channel in its scan slot.
  typedef enum logic [1:0] {
    SLOT_CLEAR  = 2'd0,
    SLOT_COUNT  = 2'd1,
    SLOT_TOGGLE = 2'd2
  } slot_act_e;

endpackage

// File: rtl/di_scan_debounce_ctrl_evt_fifo.sv
// Synchronous first-word-fall-through FIFO holding debounced edge events.
module evt_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_data_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_ptr_q;
  logic [AW:0]  rd_ptr_q;
  logic         do_wr;
  logic         do_rd;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd     = rd_en_i && !empty_o;
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/di_scan_debounce_ctrl.sv
// Round-robin debounce engine: one channel served per enabled clock, edges queued as events.
module di_scan_debounce_ctrl
  import di_scan_pkg::*;
#(
  parameter int N_CH       = N_CH_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int SHAKE      = SHAKE_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_CH-1:0]         di_i,
  output logic [N_CH-1:0]         di_o,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_CH)-1:0] evt_ch,
  output logic                    evt_level,
  output logic                    evt_ovf,
  input  logic                    ovf_clr
);

  localparam int               IDX_W   = $clog2(N_CH);
  localparam logic [CNT_W:0]   SHAKE_C = (CNT_W+1)'(SHAKE);
  localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(N_CH-1);

  logic [N_CH-1:0]  sync1_q;
  logic [N_CH-1:0]  sync2_q;
  logic [N_CH-1:0]  di_q;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   cnt_inc;
  logic [IDX_W-1:0] ch_idx_q;
  logic [IDX_W-1:0] ch_idx_d;
  logic             ovf_q;
  logic             ovf_d;
  slot_act_e        slot_act;

  logic             mismatch;
  logic             push;
  logic             pop;
  logic             drop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W:0]   fifo_rd_data;

  assign mismatch  = sync2_q[ch_idx_q] ^ di_q[ch_idx_q];
  assign push      = en && (slot_act == SLOT_TOGGLE);
  assign pop       = evt_valid && evt_ready;
  // A full FIFO still accepts the push when the head leaves on the same edge.
  assign drop      = push && fifo_full && !pop;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    slot_act = SLOT_CLEAR;
    cnt_inc  = {1'b0, cnt_q[ch_idx_q]} + (CNT_W+1)'(1);
    if (mismatch) slot_act = (cnt_inc >= SHAKE_C) ? SLOT_TOGGLE : SLOT_COUNT;

    cnt_d = '0;
    if (slot_act == SLOT_COUNT) cnt_d = cnt_inc[CNT_W-1:0];

    ch_idx_d = (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + IDX_W'(1);

    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      di_q     <= '0;
      ch_idx_q <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= di_i;
      sync2_q <= sync1_q;
      if (en) begin
        ch_idx_q        <= ch_idx_d;
        cnt_q[ch_idx_q] <= cnt_d;
        if (slot_act == SLOT_TOGGLE) di_q[ch_idx_q] <= ~di_q[ch_idx_q];
      end
      ovf_q <= ovf_d;
    end
  end

  evt_fifo #(
    .W     (IDX_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_evt_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (push && !drop),
    .wr_data_i ({ch_idx_q, ~di_q[ch_idx_q]}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign di_o                = di_q;
  assign evt_valid           = !fifo_empty;
  assign {evt_ch, evt_level} = fifo_rd_data;
  assign evt_ovf             = ovf_q;

endmodule

// File: tb/tb_di_scan_debounce_ctrl.sv
// Directed and randomized checks of the scanned debouncer against an event-level reference model.
module tb_di_scan_debounce_ctrl;

  localparam int N  = 4;
  localparam int CW = 6;
  localparam int SH = 3;
  localparam int D  = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [N-1:0]  di_i;
  logic [N-1:0]  di_o;
  logic          evt_valid;
  logic          evt_ready;
  logic [IW-1:0] evt_ch;
  logic          evt_level;
  logic          evt_ovf;
  logic          ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: two-sample input delay, a free-running slot number, per-channel
  // streak of disagreeing samples, and a bounded queue of {ch, level} events.
  logic [N-1:0] m_s1, m_s2, m_lvl;
  int           m_run [N];
  int           m_slot;
  logic         m_ovf;
  logic [IW:0]  m_q [$];

  always #10 clk = ~clk;

  di_scan_debounce_ctrl #(
    .N_CH(N), .CNT_W(CW), .SHAKE(SH), .FIFO_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .di_i(di_i), .di_o(di_o),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_level(evt_level), .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit push_pending();
    return !rst && en && (m_s2[m_slot] != m_lvl[m_slot]) && (m_run[m_slot] + 1 >= SH);
  endfunction

  task automatic compare_all();
    check("di_o", {28'd0, di_o}, {28'd0, m_lvl});
    check("evt_valid", {31'd0, evt_valid}, {31'd0, m_q.size() > 0});
    check("evt_ovf", {31'd0, evt_ovf}, {31'd0, m_ovf});
    if (m_q.size() > 0) check("evt_head", {29'd0, evt_ch, evt_level}, {29'd0, m_q[0]});
  endtask

  task automatic tick();
    bit drop;
    int c;
    drop = 1'b0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0; m_slot = 0; m_ovf = 1'b0;
      foreach (m_run[i]) m_run[i] = 0;
      m_q.delete();
    end else begin
      if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
      if (en) begin
        c = m_slot;
        if (m_s2[c] == m_lvl[c]) m_run[c] = 0;
        else if (m_run[c] + 1 >= SH) begin
          m_lvl[c] = ~m_lvl[c];
          m_run[c] = 0;
          if (m_q.size() < D) m_q.push_back({IW'(c), m_lvl[c]});
          else drop = 1'b1;
        end else m_run[c]++;
        m_slot = (m_slot + 1) % N;
      end
      if (drop) m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_s2 = m_s1;
      m_s1 = di_i;
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic lv [8];
    int   k;
    lv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1; en = 1'b0; di_i = '1; evt_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) tick();
    check("rst_di_o", {28'd0, di_o}, 32'd0);
    check("rst_valid", {31'd0, evt_valid}, 32'd0);
    check("rst_ovf", {31'd0, evt_ovf}, 32'd0);

    rst = 1'b0; di_i = '0; en = 1'b1;
    repeat (4) tick();

    // Clean rising edge on channel 2.
    di_i[2] = 1'b1;
    k = 0;
    while (!di_o[2] && k < 14) begin tick(); k++; end
    check("edge_within_14", {31'd0, di_o[2]}, 32'd1);
    check("edge_evt", {28'd0, evt_valid, evt_ch, evt_level}, 32'hD);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    check("edge_popped", {31'd0, evt_valid}, 32'd0);

    // Glitch covering exactly two channel-1 slots.
    di_i[1] = 1'b1; repeat (8) tick();
    di_i[1] = 1'b0; repeat (16) tick();
    check("glitch_di", {31'd0, di_o[1]}, 32'd0);
    check("glitch_evt", {31'd0, evt_valid}, 32'd0);

    // Nine edges with no consumer: eight queued, one dropped.
    di_i = 4'b1111; repeat (16) tick();
    di_i = 4'b0000; repeat (16) tick();
    di_i = 4'b0011; repeat (16) tick();
    check("ovf_set", {31'd0, evt_ovf}, 32'd1);
    check("ovf_di", {28'd0, di_o}, 32'h3);
    evt_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", {31'd0, evt_valid}, 32'd1);
      check("drain_level", {31'd0, evt_level}, {31'd0, lv[i]});
      tick();
    end
    evt_ready = 1'b0;
    check("drain_empty", {31'd0, evt_valid}, 32'd0);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    check("ovf_clr", {31'd0, evt_ovf}, 32'd0);

    // Fill the FIFO, then push while the head is popped on the same edge.
    di_i = 4'b1100; repeat (16) tick();
    di_i = 4'b0011; repeat (16) tick();
    check("full_valid", {31'd0, evt_valid}, 32'd1);
    di_i = 4'b0111;
    k = 0;
    while (!di_o[2] && k < 20) begin
      evt_ready = push_pending();
      tick();
      k++;
    end
    evt_ready = 1'b0;
    check("fpp_toggle", {31'd0, di_o[2]}, 32'd1);
    check("fpp_no_ovf", {31'd0, evt_ovf}, 32'd0);
    evt_ready = 1'b1;
    repeat (7) tick();
    check("fpp_last", {29'd0, evt_ch, evt_level}, 32'h5);
    tick();
    evt_ready = 1'b0;
    check("fpp_empty", {31'd0, evt_valid}, 32'd0);

    // Freeze after two disagreeing slots, then resume.
    di_i[3] = 1'b1;
    k = 0;
    while (m_run[3] != 2 && k < 20) begin tick(); k++; end
    en = 1'b0; repeat (10) tick();
    check("frz_hold", {31'd0, di_o[3]}, 32'd0);
    en = 1'b1;
    k = 0;
    while (!di_o[3] && k < N) begin tick(); k++; end
    check("frz_resume", {31'd0, di_o[3]}, 32'd1);

    // Reset after two disagreeing slots restarts the count.
    rst = 1'b1; tick(); rst = 1'b0;
    di_i = 4'b1000;
    k = 0;
    while (m_run[3] != 2 && k < 20) begin tick(); k++; end
    rst = 1'b1; tick(); rst = 1'b0;
    repeat (10) tick();
    check("rst_restart_hold", {31'd0, di_o[3]}, 32'd0);
    repeat (4) tick();
    check("rst_restart_toggle", {31'd0, di_o[3]}, 32'd1);
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;

    // Randomized traffic: slow consumer first, then fast.
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 23) == 0) di_i[b] = ~di_i[b];
      en        = ($urandom_range(0, 7) != 0);
      evt_ready = (i < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 2) != 0);
      ovf_clr   = ($urandom_range(0, 40) == 0);
      rst       = ($urandom_range(0, 700) == 0);
      tick();
    end
    rst = 1'b0; en = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
